// File: rtl/riscv_alu_top.sv
// Registered RV32I integer ALU for OP and OP-IMM instructions.
// Decodes the raw instruction fields and registers one result per clock.
module riscv_alu_top #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] RS1,
  input  logic [WIDTH-1:0] RS2,
  input  logic [2:0]       Funct3,
  input  logic [6:0]       Funct7,
  input  logic [11:0]      Imm_reg,
  input  logic [4:0]       Shamt,
  input  logic [6:0]       opcode,
  output logic [WIDTH-1:0] RD
);

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_SLL,
    OP_SLT,
    OP_SLTU,
    OP_XOR,
    OP_SRL,
    OP_SRA,
    OP_OR,
    OP_AND
  } alu_op_e;

  alu_op_e          op;
  logic [WIDTH-1:0] opb;
  logic [4:0]       sh;
  logic [WIDTH-1:0] imm_sx;
  logic             is_r;
  logic             is_i;
  logic             f7_base;
  logic             f7_alt;
  logic [WIDTH-1:0] rd_d;
  logic [WIDTH-1:0] rd_q;

  assign imm_sx  = {{(WIDTH-12){Imm_reg[11]}}, Imm_reg};
  assign is_r    = (opcode == OPC_OP);
  assign is_i    = (opcode == OPC_IMM);
  assign f7_base = (Funct7 == F7_BASE);
  assign f7_alt  = (Funct7 == F7_ALT);

  // Decode: anything not matched stays OP_NONE and yields zero.
  always_comb begin
    op  = OP_NONE;
    opb = RS2;
    sh  = RS2[4:0];
    if (is_r) begin
      case (Funct3)
        3'b000: begin
          if (f7_base)     op = OP_ADD;
          else if (f7_alt) op = OP_SUB;
        end
        3'b001: if (f7_base) op = OP_SLL;
        3'b010: if (f7_base) op = OP_SLT;
        3'b011: if (f7_base) op = OP_SLTU;
        3'b100: if (f7_base) op = OP_XOR;
        3'b101: begin
          if (f7_base)     op = OP_SRL;
          else if (f7_alt) op = OP_SRA;
        end
        3'b110: if (f7_base) op = OP_OR;
        3'b111: if (f7_base) op = OP_AND;
        default: op = OP_NONE;
      endcase
    end else if (is_i) begin
      opb = imm_sx;
      sh  = Shamt;
      case (Funct3)
        3'b000: op = OP_ADD;
        3'b010: op = OP_SLT;
        3'b011: op = OP_SLTU;
        3'b100: op = OP_XOR;
        3'b110: op = OP_OR;
        3'b111: op = OP_AND;
        3'b001: if (f7_base) op = OP_SLL;
        3'b101: begin
          if (f7_base)     op = OP_SRL;
          else if (f7_alt) op = OP_SRA;
        end
        default: op = OP_NONE;
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    unique case (op)
      OP_ADD:  rd_d = RS1 + opb;
      OP_SUB:  rd_d = RS1 - opb;
      OP_SLL:  rd_d = RS1 << sh;
      OP_SLT:  rd_d = {{(WIDTH-1){1'b0}},
                       ($signed(RS1) < $signed(opb))};
      OP_SLTU: rd_d = {{(WIDTH-1){1'b0}}, (RS1 < opb)};
      OP_XOR:  rd_d = RS1 ^ opb;
      OP_SRL:  rd_d = RS1 >> sh;
      OP_SRA:  rd_d = WIDTH'($signed(RS1) >>> sh);
      OP_OR:   rd_d = RS1 | opb;
      OP_AND:  rd_d = RS1 & opb;
      default: rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_q <= '0;
    else      rd_q <= rd_d;
  end

  assign RD = rd_q;

endmodule

// File: tb/tb_riscv_alu_top.sv
// Self-checking bench for riscv_alu_top.
// Vector table plus reset and hold sequences, scoreboard queue.
module tb_riscv_alu_top;

  localparam logic [6:0] R = 7'b0110011;
  localparam logic [6:0] I = 7'b0010011;

  logic        clk;
  logic        rst;
  logic [31:0] RS1;
  logic [31:0] RS2;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [11:0] Imm_reg;
  logic [4:0]  Shamt;
  logic [6:0]  opcode;
  logic [31:0] RD;

  riscv_alu_top #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .RS1     (RS1),
    .RS2     (RS2),
    .Funct3  (Funct3),
    .Funct7  (Funct7),
    .Imm_reg (Imm_reg),
    .Shamt   (Shamt),
    .opcode  (opcode),
    .RD      (RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [11:0] imm;
    logic [4:0]  shamt;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          n_chk;
  int          n_fail;

  function automatic vec_t mk(string nm, logic [6:0] opc,
                              logic [2:0] f3, logic [6:0] f7,
                              logic [31:0] a, logic [31:0] b,
                              logic [11:0] imm, logic [4:0] shamt,
                              logic [31:0] exp);
    vec_t v;
    v.name = nm; v.opc = opc; v.f3 = f3; v.f7 = f7;
    v.a = a; v.b = b; v.imm = imm; v.shamt = shamt;
    v.exp = exp;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: RD=%08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    opcode  = v.opc;
    Funct3  = v.f3;
    Funct7  = v.f7;
    RS1     = v.a;
    RS2     = v.b;
    Imm_reg = v.imm;
    Shamt   = v.shamt;
    sb.push_back(v.exp);
  endtask

  task automatic check_pop(string nm);
    logic [31:0] e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, RD=%08h", nm, RD);
    end else begin
      e = sb.pop_front();
      chk(nm, RD, e);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b0;
    RS1 = '0; RS2 = '0; Funct3 = '0; Funct7 = '0;
    Imm_reg = '0; Shamt = '0; opcode = '0;

    vecs.push_back(mk("add_wrap", R, 3'b000, 7'h00,
      32'hFFFFFFFF, 32'h1, 12'h0, 5'd0, 32'h0));
    vecs.push_back(mk("sub", R, 3'b000, 7'h20,
      32'h5, 32'h7, 12'h0, 5'd0, 32'hFFFFFFFE));
    vecs.push_back(mk("slt", R, 3'b010, 7'h00,
      32'hFFFFFFFF, 32'h1, 12'h0, 5'd0, 32'h1));
    vecs.push_back(mk("sltu", R, 3'b011, 7'h00,
      32'hFFFFFFFF, 32'h1, 12'h0, 5'd0, 32'h0));
    vecs.push_back(mk("sltiu", I, 3'b011, 7'h7F,
      32'h1, 32'h0, 12'hFFF, 5'd31, 32'h1));
    vecs.push_back(mk("sra", R, 3'b101, 7'h20,
      32'h80000000, 32'd36, 12'h0, 5'd0, 32'hF8000000));
    vecs.push_back(mk("srl", R, 3'b101, 7'h00,
      32'h80000000, 32'd4, 12'h0, 5'd0, 32'h08000000));
    vecs.push_back(mk("srai", I, 3'b101, 7'h20,
      32'h80000000, 32'h0, 12'h41F, 5'd31, 32'hFFFFFFFF));
    vecs.push_back(mk("slli", I, 3'b001, 7'h00,
      32'h1, 32'h0, 12'h01F, 5'd31, 32'h80000000));
    vecs.push_back(mk("addi", I, 3'b000, 7'h7F,
      32'h10, 32'h0, 12'hFFF, 5'd31, 32'h0000000F));
    vecs.push_back(mk("andi", I, 3'b111, 7'h40,
      32'hFFFF00FF, 32'h0, 12'h800, 5'd0, 32'hFFFF0000));
    vecs.push_back(mk("xori", I, 3'b100, 7'h3F,
      32'h12345678, 32'h0, 12'h7FF, 5'd31, 32'h12345187));
    vecs.push_back(mk("bad_opcode", 7'b0000011, 3'b000, 7'h00,
      32'h5, 32'h7, 12'h7, 5'd7, 32'h0));
    vecs.push_back(mk("bad_f7_add", R, 3'b000, 7'h01,
      32'h5, 32'h7, 12'h0, 5'd0, 32'h0));
    vecs.push_back(mk("sll", R, 3'b001, 7'h00,
      32'h1, 32'd33, 12'h0, 5'd0, 32'h2));
    vecs.push_back(mk("xor", R, 3'b100, 7'h00,
      32'hA5A5A5A5, 32'hFFFF0000, 12'h0, 5'd0, 32'h5A5AA5A5));
    vecs.push_back(mk("or", R, 3'b110, 7'h00,
      32'h0F0F0000, 32'h000000F0, 12'h0, 5'd0, 32'h0F0F00F0));
    vecs.push_back(mk("and", R, 3'b111, 7'h00,
      32'hF0F0F0F0, 32'h3C3C3C3C, 12'h0, 5'd0, 32'h30303030));
    vecs.push_back(mk("bad_f7_slli", I, 3'b001, 7'h20,
      32'h1, 32'h0, 12'h401, 5'd1, 32'h0));
    vecs.push_back(mk("slti", I, 3'b010, 7'h7F,
      32'hFFFFFFFE, 32'h0, 12'hFFF, 5'd31, 32'h1));
    vecs.push_back(mk("srli", I, 3'b101, 7'h00,
      32'h80000000, 32'h0, 12'h01F, 5'd31, 32'h1));
    vecs.push_back(mk("ori", I, 3'b110, 7'h40,
      32'h0, 32'h0, 12'h800, 5'd0, 32'hFFFFF800));
    vecs.push_back(mk("bad_f7_srai", I, 3'b101, 7'h10,
      32'h80000000, 32'h0, 12'h204, 5'd4, 32'h0));

    // Reset state, then release away from a clock edge.
    #2;
    chk("reset_rd", RD, 32'h0);
    @(posedge clk);
    #1;
    chk("reset_hold_edge", RD, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back: new op every cycle, result one edge later.
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_pop(vecs[i].name);
      @(negedge clk);
    end

    // Inputs changing mid-cycle must not disturb RD.
    drive(mk("hold_a", R, 3'b000, 7'h00,
      32'h100, 32'h23, 12'h0, 5'd0, 32'h123));
    @(posedge clk);
    #1;
    check_pop("hold_a");
    RS1 = 32'hDEAD0000;
    RS2 = 32'h0000BEEF;
    #2;
    chk("hold_mid", RD, 32'h123);
    @(negedge clk);
    chk("hold_negedge", RD, 32'h123);
    sb.push_back(32'hDEADBEEF);
    @(posedge clk);
    #1;
    check_pop("hold_next_edge");

    // Async reset mid-cycle discards the held result.
    @(negedge clk);
    drive(mk("pre_reset", I, 3'b000, 7'h00,
      32'h1234, 32'h0, 12'h0, 5'd0, 32'h1234));
    @(posedge clk);
    #1;
    check_pop("pre_reset");
    #2;
    rst = 1'b0;
    #1;
    sb.delete();
    chk("async_reset", RD, 32'h0);
    @(posedge clk);
    #1;
    chk("reset_low_edge", RD, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(mk("post_reset", R, 3'b000, 7'h20,
      32'h5, 32'h7, 12'h0, 5'd0, 32'hFFFFFFFE));
    #1;
    chk("post_release_pre_edge", RD, 32'h0);
    @(posedge clk);
    #1;
    check_pop("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
